// File: rtl/pe_loader_pkg.sv
// ----------------------------------------------------------------------------
// pe_loader_pkg
// Shared definitions for the PE loader slice: default frame geometry, the
// loader FSM state type and a counter-width helper.
// No ports (package).
// ----------------------------------------------------------------------------
package pe_loader_pkg;

    localparam int unsigned PE_DATA_WIDTH  = 16;
    localparam int unsigned PE_LOAD_NUM    = 8;
    localparam int unsigned PE_OUT_NUM     = 4;
    localparam int unsigned PE_FIFO_DEPTH  = 64;
    localparam int unsigned PE_WDOG_CYCLES = 4096;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BURST = 2'b01,
        RUN   = 2'b10
    } state_e;

    // Bits needed for a counter running 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pe_loader_if.sv
// ----------------------------------------------------------------------------
// pe_loader_if
// Groups the upstream sample stream and the PE load/result signals.
//   s_valid/s_data/s_ready : upstream valid/ready stream, s_data = {imag, real}
//   din_pe_v/din_pe        : load burst towards the PE
//   dout_pe_v              : PE result strobe (counted only)
// Modports: slave  = the loader itself
//           master = the environment (upstream source + PE)
// ----------------------------------------------------------------------------
interface pe_loader_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic                      s_valid;
    logic [2*DATA_WIDTH-1:0]   s_data;
    logic                      s_ready;
    logic                      din_pe_v;
    logic [2*DATA_WIDTH-1:0]   din_pe;
    logic                      dout_pe_v;

    modport slave (
        input  s_valid, s_data, dout_pe_v,
        output s_ready, din_pe_v, din_pe
    );

    modport master (
        output s_valid, s_data, dout_pe_v,
        input  s_ready, din_pe_v, din_pe
    );
endinterface

// File: rtl/pe_loader_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered, first-word-fall-through read data.
//   clk, rst : clock, asynchronous active-low reset
//   push/din : write strobe and data (ignored when full)
//   pop      : consume the head word (ignored when empty)
//   dout     : head word, registered, valid whenever !empty
//   count    : occupancy 0..DEPTH
//   full     : count == DEPTH
//   empty    : count == 0
// DEPTH must be a power of two (pointers wrap naturally).
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign count   = count_q;
    assign dout    = dout_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // The output register always holds the word that will be at the head
        // after this edge; when that slot is being written right now the
        // memory does not have it yet, so bypass the incoming word.
        if (do_push && (wr_ptr_q == rd_ptr_d)) dout_d = din;
        else                                   dout_d = mem[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end

endmodule

// File: rtl/pe_loader.sv
// ----------------------------------------------------------------------------
// pe_loader
// Upstream feeder for one PE. Buffers a valid/ready stream of complex samples
// and emits each frame as one gap-free burst of LOAD_NUM words, then waits for
// OUT_NUM result strobes before the next burst may start.
//   clk       : clock
//   rst       : asynchronous active-low reset (aborts any frame, drops data)
//   io        : pe_loader_if.slave (s_valid/s_data/s_ready, din_pe_v/din_pe,
//               dout_pe_v)
//   busy      : frame in flight (BURST or RUN)
//   fifo_cnt  : current buffer occupancy
//   wdog_err  : sticky RUN-timeout flag (only with PE_LOADER_WDOG_EN)
// Optional feature macro: PE_LOADER_WDOG_EN adds parameter WDOG_CYCLES and
// port wdog_err; RUN is abandoned after WDOG_CYCLES cycles without all results.
// ----------------------------------------------------------------------------
module pe_loader
    import pe_loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = PE_DATA_WIDTH,
    parameter int unsigned LOAD_NUM    = PE_LOAD_NUM,
    parameter int unsigned OUT_NUM     = PE_OUT_NUM,
    parameter int unsigned FIFO_DEPTH  = PE_FIFO_DEPTH
`ifdef PE_LOADER_WDOG_EN
    , parameter int unsigned WDOG_CYCLES = PE_WDOG_CYCLES
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    pe_loader_if.slave                    io,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
`ifdef PE_LOADER_WDOG_EN
    , output logic                        wdog_err
`endif
);
    localparam int unsigned SW    = 2 * DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BC_W  = cnt_width(LOAD_NUM);
    localparam int unsigned OC_W  = cnt_width(OUT_NUM);

    state_e            state_q, state_d;
    logic [BC_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic [OC_W-1:0]   out_cnt_q, out_cnt_d;
    logic              din_v_q, din_v_d;
    logic [SW-1:0]     din_q, din_d;

    logic              pop_req;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [SW-1:0]     fifo_dout;
    logic [CNT_W-1:0]  fifo_count;
    logic              frame_ready;
    logic              frame_done;

`ifdef PE_LOADER_WDOG_EN
    localparam int unsigned WC_W = cnt_width(WDOG_CYCLES);
    logic [WC_W-1:0]   wdog_cnt_q, wdog_cnt_d;
    logic              wdog_err_q, wdog_err_d;
    assign wdog_err = wdog_err_q;
`endif

    // Not ready while reset is held so upstream cannot mistake a held-off
    // handshake for an accepted word.
    assign io.s_ready  = rst & ~fifo_full;
    assign fifo_push   = io.s_valid & io.s_ready;
    assign fifo_pop    = pop_req & ~fifo_empty;
    assign frame_ready = (fifo_count >= CNT_W'(LOAD_NUM));
    assign frame_done  = io.dout_pe_v && (out_cnt_q == OC_W'(OUT_NUM - 1));

    assign fifo_cnt    = fifo_count;
    assign busy        = (state_q != IDLE);
    assign io.din_pe_v = din_v_q;
    assign io.din_pe   = din_q;

    sync_fifo #(
        .WIDTH (SW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (io.s_data),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        out_cnt_d   = out_cnt_q;
        pop_req     = 1'b0;
        din_v_d     = 1'b0;
        din_d       = '0;
`ifdef PE_LOADER_WDOG_EN
        wdog_cnt_d  = '0;
        wdog_err_d  = wdog_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                // First word leaves on the same edge as the decision, so the
                // burst counter already points at the second word.
                if (frame_ready) begin
                    pop_req = 1'b1;
                    din_v_d = 1'b1;
                    din_d   = fifo_dout;
                    if (LOAD_NUM == 1) begin
                        state_d     = RUN;
                        burst_cnt_d = '0;
                    end else begin
                        state_d     = BURST;
                        burst_cnt_d = BC_W'(1);
                    end
                end
            end
            BURST: begin
                pop_req = 1'b1;
                din_v_d = 1'b1;
                din_d   = fifo_dout;
                if (burst_cnt_q == BC_W'(LOAD_NUM - 1)) begin
                    state_d     = RUN;
                    burst_cnt_d = '0;
                end else begin
                    burst_cnt_d = burst_cnt_q + BC_W'(1);
                end
            end
            RUN: begin
                if (frame_done) begin
                    state_d   = IDLE;
                    out_cnt_d = '0;
                end else begin
                    if (io.dout_pe_v) out_cnt_d = out_cnt_q + OC_W'(1);
`ifdef PE_LOADER_WDOG_EN
                    wdog_cnt_d = wdog_cnt_q + WC_W'(1);
                    if (wdog_cnt_q == WC_W'(WDOG_CYCLES - 1)) begin
                        state_d    = IDLE;
                        out_cnt_d  = '0;
                        wdog_cnt_d = '0;
                        wdog_err_d = 1'b1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            burst_cnt_q <= '0;
            out_cnt_q   <= '0;
            din_v_q     <= 1'b0;
            din_q       <= '0;
`ifdef PE_LOADER_WDOG_EN
            wdog_cnt_q  <= '0;
            wdog_err_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            out_cnt_q   <= out_cnt_d;
            din_v_q     <= din_v_d;
            din_q       <= din_d;
`ifdef PE_LOADER_WDOG_EN
            wdog_cnt_q  <= wdog_cnt_d;
            wdog_err_q  <= wdog_err_d;
`endif
        end
    end

endmodule
